// File: rtl/i2c_master_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : i2c_master_controller
// Brief   : Bit-level I2C master write sequencer driving an external shift
//           register (Load/Shift/ShiftCLK) and the SCL/SDA bus lines.
// Revision: 1.0 - initial release
// ============================================================================
module i2c_master_controller #(
    parameter int CLK_DIV = 125
) (
    input  logic CLK,
    input  logic RESET,
    input  logic Go,
    input  logic Last,
    input  logic ShiftOut,
    input  logic SDA_in,
    output logic Load,
    output logic Shift,
    output logic ShiftCLK,
    output logic SCL,
    output logic SDA_out,
    output logic Busy,
    output logic Done,
    output logic AckErr
);

    localparam int                c_qw   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_qw-1:0]   c_qmax = c_qw'(CLK_DIV - 1);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_start = 3'd1;
    localparam logic [2:0] c_st_bit   = 3'd2;
    localparam logic [2:0] c_st_ack   = 3'd3;
    localparam logic [2:0] c_st_stop  = 3'd4;

    logic [2:0]      r_state;
    logic [c_qw-1:0] r_qcnt;
    logic [1:0]      r_phase;
    logic [2:0]      r_bitcnt;

    logic [2:0]      w_nstate;
    logic [c_qw-1:0] w_nq;
    logic [1:0]      w_nph;
    logic [2:0]      w_nbit;

    logic w_qlast;
    logic w_state_end;
    logic w_first;
    logic w_go_acc;
    logic w_ack_smp;
    logic w_nack_next;
    logic w_last_cyc_next;
    logic w_scl_n;
    logic w_sda_n;
    logic w_load_n;
    logic w_shclk_n;

    assign w_qlast     = (r_qcnt == c_qmax);
    assign w_state_end = w_qlast && (r_phase == 2'd3);
    assign w_first     = (r_qcnt == '0) && (r_phase == 2'd0);
    assign w_go_acc    = (r_state == c_st_idle) && Go;
    assign w_ack_smp   = (r_state == c_st_ack) && (r_phase == 2'd2) && w_qlast;
    // NACK value as it will stand after this edge (matters when CLK_DIV=1)
    assign w_nack_next = w_ack_smp ? SDA_in : AckErr;

    // Sequencing: quarter counter, phase and bit counter
    always_comb begin
        w_nstate = r_state;
        w_nq     = r_qcnt;
        w_nph    = r_phase;
        w_nbit   = r_bitcnt;
        if (r_state != c_st_idle) begin
            if (w_qlast) begin
                w_nq  = '0;
                w_nph = r_phase + 2'd1;
            end else begin
                w_nq = r_qcnt + 1'b1;
            end
        end
        case (r_state)
            c_st_idle: begin
                if (Go) begin
                    w_nstate = c_st_start;
                    w_nq     = '0;
                    w_nph    = 2'd0;
                end
            end
            c_st_start: begin
                if (w_state_end) begin
                    w_nstate = c_st_bit;
                    w_nbit   = 3'd0;
                end
            end
            c_st_bit: begin
                if (w_state_end) begin
                    if (r_bitcnt == 3'd7) begin
                        w_nstate = c_st_ack;
                    end else begin
                        w_nbit = r_bitcnt + 3'd1;
                    end
                end
            end
            c_st_ack: begin
                // Load was raised for this final cycle only when another byte follows
                if (w_state_end) begin
                    if (Load) begin
                        w_nstate = c_st_bit;
                        w_nbit   = 3'd0;
                    end else begin
                        w_nstate = c_st_stop;
                    end
                end
            end
            c_st_stop: begin
                if (w_state_end) begin
                    w_nstate = c_st_idle;
                end
            end
            default: begin
                w_nstate = c_st_idle;
                w_nq     = '0;
                w_nph    = 2'd0;
            end
        endcase
    end

    assign w_last_cyc_next = (w_nq == c_qmax) && (w_nph == 2'd3);

    // Registered outputs are derived from the state the next cycle will be in
    always_comb begin
        w_scl_n = 1'b1;
        w_sda_n = SDA_out;
        case (w_nstate)
            c_st_idle: begin
                w_sda_n = 1'b1;
            end
            c_st_start: begin
                w_sda_n = ~w_nph[1];
            end
            c_st_bit: begin
                w_scl_n = w_nph[1];
                // SDA moves one CLK after SCL falls: the shift tick lands on that
                // same edge, so ShiftOut is only valid one cycle into phase 0.
                if ((r_state == c_st_bit) && w_first) begin
                    w_sda_n = ShiftOut;
                end
            end
            c_st_ack: begin
                w_scl_n = w_nph[1];
                if ((r_state == c_st_ack) && w_first) begin
                    w_sda_n = 1'b1;
                end
            end
            c_st_stop: begin
                w_scl_n = w_nph[1];
                if (w_nph == 2'd3) begin
                    w_sda_n = 1'b1;
                end else if ((r_state == c_st_stop) && w_first) begin
                    w_sda_n = 1'b0;
                end
            end
            default: begin
                w_scl_n = 1'b1;
                w_sda_n = 1'b1;
            end
        endcase
    end

    // Last and the ACK result are taken on the edge entering the final ACK cycle
    assign w_load_n  = w_go_acc ||
                       ((w_nstate == c_st_ack) && w_last_cyc_next && !Last && !w_nack_next);
    assign w_shclk_n = (w_nstate == c_st_bit) && w_last_cyc_next && (w_nbit != 3'd7);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state  <= c_st_idle;
            r_qcnt   <= '0;
            r_phase  <= 2'd0;
            r_bitcnt <= 3'd0;
            SCL      <= 1'b1;
            SDA_out  <= 1'b1;
            Load     <= 1'b0;
            Shift    <= 1'b0;
            ShiftCLK <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            AckErr   <= 1'b0;
        end else begin
            r_state  <= w_nstate;
            r_qcnt   <= w_nq;
            r_phase  <= w_nph;
            r_bitcnt <= w_nbit;
            SCL      <= w_scl_n;
            SDA_out  <= w_sda_n;
            Load     <= w_load_n;
            Shift    <= (w_nstate == c_st_bit);
            ShiftCLK <= w_shclk_n;
            Busy     <= (w_nstate != c_st_idle);
            Done     <= (r_state == c_st_stop) && (w_nstate == c_st_idle);
            AckErr   <= w_go_acc ? 1'b0 : w_nack_next;
        end
    end

endmodule
`default_nettype wire

// File: doc/i2c_master_controller.md
Name: i2c_master_controller

Overview:
Bit-level I2C master write sequencer that sits directly upstream of the I2C shift register.
- Drives the register's Load, Shift and ShiftCLK controls and consumes its serial ShiftOut.
- Generates SCL and open-drain SDA timing from CLK, including START, 8 data bits, ACK sampling and STOP.
- Supports multi-byte writes; each Load pulse doubles as the "next byte" strobe to the data source feeding the register.

Parameters:
CLK_DIV, 125, CLK cycles per SCL quarter-period (SCL period = 4*CLK_DIV; 125 gives 100 kHz from 50 MHz); legal range >= 1

Ports:
CLK  in  1  system clock, all state on rising edge
RESET  in  1  asynchronous, active-high reset
Go  in  1  start-transaction request, sampled only in IDLE
Last  in  1  sampled in ACK phase 3 last cycle: 1 = issue STOP after this byte, 0 = send another byte
ShiftOut  in  1  serial MSB from the shift register
SDA_in  in  1  sampled SDA bus level
Load  out  1  one-cycle pulse: shift register loads DataIn
Shift  out  1  shift enable, high for the whole BIT state
ShiftCLK  out  1  one-cycle shift tick
SCL  out  1  I2C clock (1 = released/high)
SDA_out  out  1  SDA drive (0 = pull low, 1 = release)
Busy  out  1  high from Go acceptance until Done
Done  out  1  one-cycle pulse at return to IDLE
AckErr  out  1  latched NACK flag, cleared on Go acceptance

Behaviour:
- All outputs registered.
- Reset values: SCL=1, SDA_out=1, Load=0, Shift=0, ShiftCLK=0, Busy=0, Done=0, AckErr=0, state=IDLE, counters=0.
- Reset mid-transaction releases both lines immediately (asynchronous); no STOP is generated.

Timing counters:
- qcnt counts 0..CLK_DIV-1; its wrap advances phase 0..3.
- bitcnt counts 0..7.
- qcnt and phase reset to 0 on every state entry.

State IDLE:
- SCL=1, SDA_out=1.
- Go=1 at edge t: next cycle Busy=1, Load=1 (one cycle), AckErr=0, enter START.
- Go while Busy is ignored.

State START:
- SCL=1 in all phases.
- SDA_out=1 in phases 0-1, 0 in phases 2-3.
- After phase 3, enter BIT with bitcnt=0.

State BIT:
- SCL=0 in phases 0-1, 1 in phases 2-3.
- SDA_out=ShiftOut; it changes only at phase 0 start.
- Shift=1 throughout.
- For bitcnt 0..6: ShiftCLK=1 on the last cycle of phase 3, bitcnt increments.
- For bitcnt 7: no ShiftCLK; enter ACK.

State ACK:
- SCL pattern as BIT; SDA_out=1.
- AckErr <= SDA_in on the last cycle of phase 2.
- At the end of phase 3:
  - Last=1 or NACK: enter STOP.
  - Otherwise: Load=1 for the last cycle of phase 3, then enter BIT with bitcnt=0.
- NACK forces STOP regardless of Last.

State STOP:
- Phases 0-1: SCL=0, SDA_out=0.
- Phase 2: SCL=1, SDA_out=0.
- Phase 3: SCL=1, SDA_out=1.
- Then IDLE with Done=1 for one cycle and Busy=0 in the same cycle.

Latency:
- Single-byte transaction = 44*CLK_DIV cycles from Load pulse to Done.
- Each extra byte adds 36*CLK_DIV cycles.

Invariants:
- SDA changes only while SCL=0, except the START and STOP edges.
- Load and ShiftCLK are never high in the same cycle.
- Simultaneous Go and RESET: RESET wins.

Test Plan:
- CLK_DIV=4, register preloaded via Load with 0xA5, Last=1, SDA_in=0 in ACK -> SDA_out at each SCL rise = 1,0,1,0,0,1,0,1; exactly 7 ShiftCLK pulses; Done 176 cycles after Load; AckErr=0.
- Same, but SDA_in=1 during ACK -> AckErr=1, STOP issued (SDA rises while SCL=1), Done pulses; AckErr stays 1 until the next Go.
- Two bytes 0x3C then 0xF0, Last=0 then 1 -> second Load pulse on the last cycle of the first ACK; no STOP between bytes; serial stream 00111100 then 11110000; Done at 320 cycles.
- Go pulsed repeatedly while Busy -> no extra Load, no state disturbance, single Done.
- RESET asserted during bit 3 -> SCL=1, SDA_out=1, Busy=0 before the next CLK edge; a Go afterwards starts a clean START.
- CLK_DIV=1 -> phases last one cycle each; the single-byte transaction completes in 44 cycles with correct bit order.
